// File: rtl/bldc_commutator_dt.sv
// ============================================================================
//  Module      : bldc_commutator_dt
//  Description : Clocked six-step Hall commutator with input synchronisation,
//                debounce, dead-time insertion, direction select, PWM chopping
//                of the high sides, invalid-Hall fault and Hall period / stall
//                measurement.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module bldc_commutator_dt #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int DEADTIME_CYCLES = 8,
   parameter int PERIOD_W        = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                dir,
   input  logic                pwm_in,
   input  logic                h1,
   input  logic                h2,
   input  logic                h3,
   output logic                a,
   output logic                b,
   output logic                c,
   output logic                aa,
   output logic                bb,
   output logic                cc,
   output logic [2:0]          sector,
   output logic                fault,
   output logic [PERIOD_W-1:0] hall_period,
   output logic                stall
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int DT_W = $clog2(DEADTIME_CYCLES + 1);
   localparam logic [DB_W-1:0]     DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DT_W-1:0]     DT_LAST = DT_W'(DEADTIME_CYCLES - 1);
   localparam logic [PERIOD_W-1:0] PER_MAX = '1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DEAD  = 2'd1,
      ST_DRIVE = 2'd2,
      ST_FAULT = 2'd3
   } state_t;

   state_t              state;
   logic [2:0]          sync1;
   logic [2:0]          sync2;
   logic [DB_W-1:0]     db_cnt;
   logic [2:0]          hall_q;
   logic                dir_q;
   logic [DT_W-1:0]     dead_cnt;
   logic [PERIOD_W-1:0] per_cnt;
   logic [5:0]          pattern;   // {A,B,C,AA,BB,CC} before PWM chopping

   logic accept;
   logic invalid;
   logic dir_chg;

   // Gate pattern for a Hall code; reverse swaps the high and low phases.
   function automatic logic [5:0] phase_pattern(input logic [2:0] code, input logic rev);
      logic [5:0] p;
      case (code)
         3'b100:  p = {3'b100, 3'b010};
         3'b110:  p = {3'b100, 3'b001};
         3'b010:  p = {3'b010, 3'b001};
         3'b011:  p = {3'b010, 3'b100};
         3'b001:  p = {3'b001, 3'b100};
         3'b101:  p = {3'b001, 3'b010};
         default: p = 6'b000000;
      endcase
      return rev ? {p[2:0], p[5:3]} : p;
   endfunction

   // A new code is taken once it has been stable long enough and differs from the held one.
   assign accept  = (sync2 != hall_q) && (db_cnt >= DB_LAST);
   assign invalid = (sync2 == 3'b000) || (sync2 == 3'b111);
   assign dir_chg = (dir != dir_q);

   // Two-stage synchroniser, stability counter and accepted Hall code.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1  <= 3'b000;
         sync2  <= 3'b000;
         db_cnt <= '0;
         hall_q <= 3'b000;
      end else begin
         sync1 <= {h1, h2, h3};
         sync2 <= sync1;
         if (sync1 != sync2)
            db_cnt <= '0;
         else if (db_cnt < DB_LAST)
            db_cnt <= db_cnt + DB_W'(1);
         if (accept)
            hall_q <= sync2;
      end
   end

   // Saturating Hall period counter, captured on every accepted change.
   always_ff @(posedge clk) begin
      if (rst) begin
         per_cnt     <= '0;
         hall_period <= '0;
      end else if (accept) begin
         hall_period <= per_cnt;
         per_cnt     <= PERIOD_W'(1);
      end else if (per_cnt != PER_MAX) begin
         per_cnt <= per_cnt + PERIOD_W'(1);
      end
   end

   assign stall = (per_cnt == PER_MAX);

   // Commutation FSM with registered gate pattern and fault flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         dead_cnt <= '0;
         dir_q    <= 1'b0;
         fault    <= 1'b0;
         pattern  <= 6'b000000;
      end else begin
         dir_q   <= dir;
         pattern <= 6'b000000;
         fault   <= 1'b0;
         if (!en) begin
            state <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: begin
                  state    <= ST_DEAD;
                  dead_cnt <= '0;
               end
               ST_DEAD: begin
                  if (accept && invalid) begin
                     state <= ST_FAULT;
                     fault <= 1'b1;
                  end else if (accept || dir_chg) begin
                     dead_cnt <= '0;
                  end else if (dead_cnt == DT_LAST) begin
                     state   <= ST_DRIVE;
                     pattern <= phase_pattern(hall_q, dir_q);
                  end else begin
                     dead_cnt <= dead_cnt + DT_W'(1);
                  end
               end
               ST_DRIVE: begin
                  if (accept && invalid) begin
                     state <= ST_FAULT;
                     fault <= 1'b1;
                  end else if (accept || dir_chg) begin
                     state    <= ST_DEAD;
                     dead_cnt <= '0;
                  end else begin
                     pattern <= phase_pattern(hall_q, dir_q);
                  end
               end
               default: begin
                  state <= ST_FAULT;
                  fault <= 1'b1;
               end
            endcase
         end
      end
   end

   // Sector number of the accepted code, 7 for the two impossible codes.
   always_comb begin
      sector = 3'd7;
      case (hall_q)
         3'b100:  sector = 3'd0;
         3'b110:  sector = 3'd1;
         3'b010:  sector = 3'd2;
         3'b011:  sector = 3'd3;
         3'b001:  sector = 3'd4;
         3'b101:  sector = 3'd5;
         default: sector = 3'd7;
      endcase
   end

   assign a  = pattern[5] & pwm_in;
   assign b  = pattern[4] & pwm_in;
   assign c  = pattern[3] & pwm_in;
   assign aa = pattern[2];
   assign bb = pattern[1];
   assign cc = pattern[0];

endmodule

`default_nettype wire

// File: tb/tb_bldc_commutator_dt.sv
// ============================================================================
//  Module      : tb_bldc_commutator_dt
//  Description : Self-checking bench for bldc_commutator_dt with a cycle model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bldc_commutator_dt;

   localparam int D  = 4;
   localparam int DT = 8;

   logic clk = 1'b0;
   logic rst, en, dir, pwm_in, h1, h2, h3;
   logic a, b, c, aa, bb, cc, fault, stall;
   logic [2:0]  sector;
   logic [15:0] hall_period;
   logic a8, b8, c8, aa8, bb8, cc8, fault8, stall8;
   logic [2:0]  sector8;
   logic [7:0]  hall_period8;

   always #5 clk = ~clk;

   bldc_commutator_dt #(.DEBOUNCE_CYCLES(D), .DEADTIME_CYCLES(DT), .PERIOD_W(16)) dut (
      .clk(clk), .rst(rst), .en(en), .dir(dir), .pwm_in(pwm_in),
      .h1(h1), .h2(h2), .h3(h3),
      .a(a), .b(b), .c(c), .aa(aa), .bb(bb), .cc(cc),
      .sector(sector), .fault(fault), .hall_period(hall_period), .stall(stall));

   bldc_commutator_dt #(.DEBOUNCE_CYCLES(D), .DEADTIME_CYCLES(DT), .PERIOD_W(8)) dut8 (
      .clk(clk), .rst(rst), .en(en), .dir(dir), .pwm_in(pwm_in),
      .h1(h1), .h2(h2), .h3(h3),
      .a(a8), .b(b8), .c(c8), .aa(aa8), .bb(bb8), .cc(cc8),
      .sector(sector8), .fault(fault8), .hall_period(hall_period8), .stall(stall8));

   // Sector tables: Hall code, forward high phase, forward low phase (0=A,1=B,2=C)
   logic [2:0] sec_code [0:5] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
   int         hi_ph    [0:5] = '{0, 0, 1, 1, 2, 2};
   int         lo_ph    [0:5] = '{1, 2, 2, 0, 0, 1};

   // Behavioural model state
   logic [2:0] hist [0:D];      // hist[k]: pin code sampled k+1 edges ago
   logic [2:0] m_hall;
   bit         m_idle, m_fault;
   int         m_dead;          // dead cycles still to serve
   logic       m_dir;
   int         m_pc16, m_per16, m_pc8, m_per8;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at t=%0t", name, got, exp, $time);
   endtask

   function automatic int sector_of(input logic [2:0] code);
      for (int i = 0; i < 6; i++) if (sec_code[i] == code) return i;
      return 7;
   endfunction

   task automatic model_edge();
      bit acc, inv, dchg, same;
      logic [2:0] cand;
      if (rst) begin
         for (int i = 0; i <= D; i++) hist[i] = 3'b000;
         m_hall = 3'b000; m_idle = 1; m_fault = 0; m_dead = 0; m_dir = 0;
         m_pc16 = 0; m_per16 = 0; m_pc8 = 0; m_per8 = 0;
         return;
      end
      cand = hist[1];
      same = 1;
      for (int i = 1; i <= D; i++) if (hist[i] != cand) same = 0;
      acc  = same && (cand != m_hall);
      inv  = acc && (cand == 3'b000 || cand == 3'b111);
      dchg = (dir != m_dir);
      if (acc) begin
         m_per16 = m_pc16; m_pc16 = 1;
         m_per8  = m_pc8;  m_pc8  = 1;
      end else begin
         if (m_pc16 < 65535) m_pc16++;
         if (m_pc8 < 255) m_pc8++;
      end
      if (!en) begin
         m_idle = 1; m_fault = 0; m_dead = 0;
      end else if (m_idle) begin
         m_idle = 0; m_dead = DT;
      end else if (m_fault) begin
         m_fault = 1;
      end else if (inv) begin
         m_fault = 1;
      end else if (acc || dchg) begin
         m_dead = DT;
      end else if (m_dead > 0) begin
         m_dead--;
      end
      if (acc) m_hall = cand;
      for (int i = D; i >= 1; i--) hist[i] = hist[i-1];
      hist[0] = {h1, h2, h3};
      m_dir = dir;
   endtask

   function automatic logic [5:0] model_gates();
      logic [5:0] g;
      int s, hp, lp;
      g = 6'b000000;
      s = sector_of(m_hall);
      if (!m_idle && !m_fault && m_dead == 0 && s < 6) begin
         hp = m_dir ? lo_ph[s] : hi_ph[s];
         lp = m_dir ? hi_ph[s] : lo_ph[s];
         g[5-hp] = pwm_in;
         g[2-lp] = 1'b1;
      end
      return g;
   endfunction

   task automatic step();
      logic [5:0] eg;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      eg = model_gates();
      chk("cycle_main", {a, b, c, aa, bb, cc, sector, fault, hall_period, stall},
          {eg, 3'(sector_of(m_hall)), m_fault, 16'(m_per16), (m_pc16 == 65535)});
      chk("cycle_p8", {hall_period8, stall8}, {8'(m_per8), (m_pc8 == 255)});
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic set_hall(input logic [2:0] code);
      {h1, h2, h3} = code;
   endtask

   initial begin
      rst = 1; en = 1; dir = 0; pwm_in = 1;
      set_hall(3'b100);
      @(negedge clk);
      run(3);
      chk("reset_state", {a, b, c, aa, bb, cc, sector, fault, hall_period, stall},
          {6'b000000, 3'd7, 1'b0, 16'd0, 1'b0});
      rst = 0;

      // Startup: dead time then sector 0 forward
      run(13);
      chk("startup_dead", {a, b, c, aa, bb, cc}, 6'b000000);
      run(1);
      chk("startup_drive", {a, b, c, aa, bb, cc, sector}, {6'b100010, 3'd0});

      // Walk the six sectors, 1000 cycles apart
      for (int k = 1; k < 6; k++) begin
         set_hall(sec_code[k]);
         run(1000);
         chk("step_sector", {29'd0, sector}, 32'(k));
         if (k == 2) chk("period_1000", {48'd0, hall_period}, 64'd1000);
      end

      // Direction change in sector 2
      set_hall(3'b010);
      run(50);
      chk("sec2_fwd", {a, b, c, aa, bb, cc}, 6'b010001);
      dir = 1;
      run(8);
      chk("dir_dead", {a, b, c, aa, bb, cc}, 6'b000000);
      run(1);
      chk("sec2_rev", {a, b, c, aa, bb, cc}, 6'b001010);
      pwm_in = 0;
      run(1);
      chk("pwm_chop", {a, b, c, aa, bb, cc}, 6'b000010);
      pwm_in = 1;

      // Short glitch on H2 must be ignored
      h2 = 0;
      run(3);
      h2 = 1;
      run(20);
      chk("glitch_ignored", {a, b, c, aa, bb, cc, sector, fault}, {6'b001010, 3'd2, 1'b0});

      // Invalid code fault, sticky until EN drops
      set_hall(3'b111);
      run(10);
      chk("fault_set", {a, b, c, aa, bb, cc, sector, fault}, {6'b000000, 3'd7, 1'b1});
      set_hall(3'b010);
      run(20);
      chk("fault_sticky", {a, b, c, aa, bb, cc, fault}, {6'b000000, 1'b1});
      en = 0;
      run(1);
      chk("fault_clear", {31'd0, fault}, 32'd0);
      en = 1;
      run(30);
      chk("fault_recover", {a, b, c, aa, bb, cc, fault}, {6'b001010, 1'b0});

      // Stall on the 8-bit counter
      run(300);
      chk("stall8", {31'd0, stall8}, 32'd1);
      chk("no_stall16", {31'd0, stall}, 32'd0);

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 59) == 0) begin
            if ($urandom_range(0, 9) == 0) set_hall(3'($urandom_range(0, 7)));
            else set_hall(sec_code[$urandom_range(0, 5)]);
         end
         if ($urandom_range(0, 299) == 0) dir = ~dir;
         en     = ($urandom_range(0, 249) != 0);
         pwm_in = 1'($urandom_range(0, 1));
         step();
      end

      // Reset in the middle of driving
      en = 0; dir = 0; pwm_in = 1;
      set_hall(3'b100);
      run(1);
      en = 1;
      run(40);
      chk("final_drive", {a, b, c, aa, bb, cc}, 6'b100010);
      rst = 1;
      run(1);
      chk("mid_reset", {a, b, c, aa, bb, cc, sector}, {6'b000000, 3'd7});
      rst = 0;
      run(5);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
